// File: rtl/reg_file_ctrl_if.sv
// reg_file_ctrl_if: bundles the signals of reg_file_ctrl apart from clk/reset.
//   core_*  : core pipeline read/write request, grant and read return
//   dbg_*   : debug port request, grant and read return
//   rf_*    : BRAM register file control, addresses, write data and read data
//   init_done : clear sequence complete
// Modports:
//   slave  - the controller (reg_file_ctrl)
//   master - the surrounding logic: requesters plus the BRAM
interface reg_file_ctrl_if;
  logic        core_rd_req;
  logic [4:0]  core_rs1_addr;
  logic [4:0]  core_rs2_addr;
  logic        core_wr_req;
  logic [4:0]  core_wr_addr;
  logic [31:0] core_wr_data;
  logic        core_gnt;
  logic        core_rvld;
  logic [31:0] core_src1_data;
  logic [31:0] core_src2_data;

  logic        dbg_req;
  logic        dbg_wr;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_wdata;
  logic        dbg_gnt;
  logic        dbg_rvld;
  logic [31:0] dbg_rdata;

  logic        init_done;

  logic        rf_reg_enabl;
  logic        rf_wr_enabl;
  logic [4:0]  rf_src1_addr;
  logic [4:0]  rf_src2_addr;
  logic [4:0]  rf_dst_addr;
  logic [31:0] rf_dst_data;
  logic [31:0] rf_src1_data;
  logic [31:0] rf_src2_data;

  modport slave (
    input  core_rd_req, core_rs1_addr, core_rs2_addr, core_wr_req, core_wr_addr, core_wr_data,
    output core_gnt, core_rvld, core_src1_data, core_src2_data,
    input  dbg_req, dbg_wr, dbg_addr, dbg_wdata,
    output dbg_gnt, dbg_rvld, dbg_rdata,
    output init_done,
    output rf_reg_enabl, rf_wr_enabl, rf_src1_addr, rf_src2_addr, rf_dst_addr, rf_dst_data,
    input  rf_src1_data, rf_src2_data
  );

  modport master (
    output core_rd_req, core_rs1_addr, core_rs2_addr, core_wr_req, core_wr_addr, core_wr_data,
    input  core_gnt, core_rvld, core_src1_data, core_src2_data,
    output dbg_req, dbg_wr, dbg_addr, dbg_wdata,
    input  dbg_gnt, dbg_rvld, dbg_rdata,
    input  init_done,
    input  rf_reg_enabl, rf_wr_enabl, rf_src1_addr, rf_src2_addr, rf_dst_addr, rf_dst_data,
    output rf_src1_data, rf_src2_data
  );
endinterface

// File: rtl/reg_file_ctrl.sv
// reg_file_ctrl: sequencer/arbiter for a 32x32 dual-read, single-write READ_FIRST BRAM
// register file with 1-cycle synchronous read.
//   - After reset, writes INIT_VALUE to all 32 entries (32 cycles), then raises init_done.
//   - Arbitrates each cycle between the core pipeline and the debug port; debug wins when
//     the core is idle or after DBG_MAX_WAIT consecutive denied cycles.
//   - x0 is never written in RUN and always reads as zero.
// Ports:
//   clk   - cpu clock
//   reset - asynchronous, active-high reset
//   bus   - reg_file_ctrl_if.slave (core, debug, init_done and BRAM signals)
// Parameters:
//   DBG_MAX_WAIT - denied debug cycles before debug is forced ahead of the core (1..15)
//   INIT_VALUE   - value written to every register during the clear sequence
// Build option:
//   RF_BYPASS_EN - when defined, a read that collides with a same-cycle write to the same
//                  nonzero address returns the new data instead of the old contents.
module reg_file_ctrl #(
  parameter int unsigned DBG_MAX_WAIT = 8,
  parameter logic [31:0] INIT_VALUE   = 32'h0
) (
  input logic            clk,
  input logic            reset,
  reg_file_ctrl_if.slave bus
);

  localparam logic [0:0] StInit = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;

  localparam logic [3:0] MaxWait = 4'(DBG_MAX_WAIT);

  logic [0:0] state_q, state_d;
  logic [4:0] clr_cnt_q, clr_cnt_d;
  logic [3:0] starve_q, starve_d;
  logic       core_rvld_q, core_rvld_d;
  logic       dbg_rvld_q, dbg_rvld_d;
  logic       src1_zero_q, src1_zero_d;
  logic       src2_zero_q, src2_zero_d;

  logic        core_req;
  logic        init_act;
  logic        run_act;
  logic        core_gnt;
  logic        dbg_gnt;
  logic        rf_reg_en;
  logic        rf_wr_en;
  logic [4:0]  rf_src1_addr;
  logic [4:0]  rf_src2_addr;
  logic [4:0]  rf_dst_addr;
  logic [31:0] rf_dst_data;
  logic [31:0] src1_ret;
  logic [31:0] src2_ret;

  // Outputs are held at zero while reset is asserted, including the combinational ones.
  assign init_act = !reset && (state_q == StInit);
  assign run_act  = !reset && (state_q == StRun);

  assign core_req = bus.core_rd_req | bus.core_wr_req;
  assign dbg_gnt  = run_act && bus.dbg_req && (!core_req || (starve_q == MaxWait));
  assign core_gnt = run_act && core_req && !dbg_gnt;

  // BRAM control
  always_comb begin
    rf_reg_en    = init_act | run_act;
    rf_wr_en     = 1'b0;
    rf_src1_addr = 5'd0;
    rf_src2_addr = 5'd0;
    rf_dst_addr  = 5'd0;
    rf_dst_data  = 32'h0;
    if (init_act) begin
      rf_wr_en    = 1'b1;
      rf_dst_addr = clr_cnt_q;
      rf_dst_data = INIT_VALUE;
    end else if (core_gnt) begin
      rf_src1_addr = bus.core_rs1_addr;
      rf_src2_addr = bus.core_rs2_addr;
      if (bus.core_wr_req) begin
        rf_dst_addr = bus.core_wr_addr;
        rf_dst_data = bus.core_wr_data;
        rf_wr_en    = (bus.core_wr_addr != 5'd0);
      end
    end else if (dbg_gnt) begin
      if (bus.dbg_wr) begin
        rf_dst_addr = bus.dbg_addr;
        rf_dst_data = bus.dbg_wdata;
        rf_wr_en    = (bus.dbg_addr != 5'd0);
      end else begin
        rf_src1_addr = bus.dbg_addr;
      end
    end
  end

  // Next state
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == StInit) begin
      clr_cnt_d = clr_cnt_q + 5'd1;
      if (clr_cnt_q == 5'd31) begin
        state_d = StRun;
      end
    end
    // Counts consecutive denied debug cycles; any grant or a dropped request restarts it.
    starve_d    = (run_act && bus.dbg_req && !dbg_gnt) ? starve_q + 4'd1 : 4'd0;
    core_rvld_d = core_gnt && bus.core_rd_req;
    dbg_rvld_d  = dbg_gnt && !bus.dbg_wr;
    src1_zero_d = (rf_src1_addr == 5'd0);
    src2_zero_d = (rf_src2_addr == 5'd0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StInit;
      clr_cnt_q   <= 5'd0;
      starve_q    <= 4'd0;
      core_rvld_q <= 1'b0;
      dbg_rvld_q  <= 1'b0;
      src1_zero_q <= 1'b0;
      src2_zero_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      starve_q    <= starve_d;
      core_rvld_q <= core_rvld_d;
      dbg_rvld_q  <= dbg_rvld_d;
      src1_zero_q <= src1_zero_d;
      src2_zero_q <= src2_zero_d;
    end
  end

`ifdef RF_BYPASS_EN
  logic [31:0] wr_data_q, wr_data_d;
  logic        byp1_q, byp1_d;
  logic        byp2_q, byp2_d;

  // rf_wr_en already excludes address 0 in RUN, and reads only happen in RUN.
  always_comb begin
    wr_data_d = rf_dst_data;
    byp1_d    = rf_wr_en && (core_rvld_d || dbg_rvld_d) && (rf_src1_addr == rf_dst_addr);
    byp2_d    = rf_wr_en && core_rvld_d && (rf_src2_addr == rf_dst_addr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_data_q <= 32'h0;
      byp1_q    <= 1'b0;
      byp2_q    <= 1'b0;
    end else begin
      wr_data_q <= wr_data_d;
      byp1_q    <= byp1_d;
      byp2_q    <= byp2_d;
    end
  end

  assign src1_ret = src1_zero_q ? 32'h0 : (byp1_q ? wr_data_q : bus.rf_src1_data);
  assign src2_ret = src2_zero_q ? 32'h0 : (byp2_q ? wr_data_q : bus.rf_src2_data);
`else
  // READ_FIRST: a colliding read returns the old contents.
  assign src1_ret = src1_zero_q ? 32'h0 : bus.rf_src1_data;
  assign src2_ret = src2_zero_q ? 32'h0 : bus.rf_src2_data;
`endif

  assign bus.core_gnt       = core_gnt;
  assign bus.dbg_gnt        = dbg_gnt;
  assign bus.core_rvld      = core_rvld_q;
  assign bus.dbg_rvld       = dbg_rvld_q;
  assign bus.core_src1_data = core_rvld_q ? src1_ret : 32'h0;
  assign bus.core_src2_data = core_rvld_q ? src2_ret : 32'h0;
  // Debug reads share the src1 port.
  assign bus.dbg_rdata      = dbg_rvld_q ? src1_ret : 32'h0;
  assign bus.init_done      = (state_q == StRun);
  assign bus.rf_reg_enabl   = rf_reg_en;
  assign bus.rf_wr_enabl    = rf_wr_en;
  assign bus.rf_src1_addr   = rf_src1_addr;
  assign bus.rf_src2_addr   = rf_src2_addr;
  assign bus.rf_dst_addr    = rf_dst_addr;
  assign bus.rf_dst_data    = rf_dst_data;

endmodule

// File: tb/tb_reg_file_ctrl.sv
// tb_reg_file_ctrl: self-checking bench for reg_file_ctrl with a behavioural READ_FIRST
// BRAM, a shadow register model and expected-read queues checked as rvld returns.
module tb_reg_file_ctrl;
  localparam int unsigned MaxWait = 8;
  localparam logic [31:0] InitVal = 32'h1;

  typedef struct packed {
    logic [31:0] s1;
    logic [31:0] s2;
  } core_exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  reg_file_ctrl_if bus ();

  reg_file_ctrl #(
    .DBG_MAX_WAIT(MaxWait),
    .INIT_VALUE  (InitVal)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // READ_FIRST BRAM, 1-cycle read
  logic [31:0] mem [32];
  logic [31:0] rd1_q, rd2_q;
  always @(posedge clk) begin
    if (bus.rf_reg_enabl) begin
      rd1_q <= mem[bus.rf_src1_addr];
      rd2_q <= mem[bus.rf_src2_addr];
      if (bus.rf_wr_enabl) mem[bus.rf_dst_addr] <= bus.rf_dst_data;
    end
  end
  assign bus.rf_src1_data = rd1_q;
  assign bus.rf_src2_data = rd2_q;

  logic [31:0] exp_rf [32];
  core_exp_t   core_q [$];
  logic [31:0] dbg_q  [$];

  function automatic logic [31:0] exp_read(input logic [4:0] addr, input logic wr,
                                           input logic [4:0] wa, input logic [31:0] wd);
    if (addr == 5'd0) return 32'h0;
`ifdef RF_BYPASS_EN
    if (wr && wa != 5'd0 && wa == addr) return wd;
`endif
    return exp_rf[addr];
  endfunction

  // Scoreboard: each rvld pulse pops the expectation queued at grant time.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.core_rvld) begin
        n_checks++;
        if (core_q.size() == 0) begin
          n_fail++;
          $display("FAIL core_rvld_spurious: rvld=1 with nothing outstanding");
        end else begin
          core_exp_t e;
          e = core_q.pop_front();
          if (bus.core_src1_data !== e.s1 || bus.core_src2_data !== e.s2) begin
            n_fail++;
            $display("FAIL core_rdata: got %h/%h required %h/%h", bus.core_src1_data,
                     bus.core_src2_data, e.s1, e.s2);
          end
        end
      end
      if (bus.dbg_rvld) begin
        n_checks++;
        if (dbg_q.size() == 0) begin
          n_fail++;
          $display("FAIL dbg_rvld_spurious: rvld=1 with nothing outstanding");
        end else begin
          logic [31:0] d;
          d = dbg_q.pop_front();
          if (bus.dbg_rdata !== d) begin
            n_fail++;
            $display("FAIL dbg_rdata: got %h required %h", bus.dbg_rdata, d);
          end
        end
      end
    end
  end

  // Drives a core request from posedge+1 until granted; returns at posedge+1 after the grant.
  task automatic core_issue(input logic rd, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic wr, input logic [4:0] wa, input logic [31:0] wd,
                            output bit granted, output logic wr_en_seen);
    granted    = 1'b0;
    wr_en_seen = 1'b0;
    bus.core_rd_req   = rd;
    bus.core_rs1_addr = rs1;
    bus.core_rs2_addr = rs2;
    bus.core_wr_req   = wr;
    bus.core_wr_addr  = wa;
    bus.core_wr_data  = wd;
    for (int c = 0; c < 16 && !granted; c++) begin
      @(negedge clk);
      if (bus.core_gnt) begin
        granted    = 1'b1;
        wr_en_seen = bus.rf_wr_enabl;
        if (rd) core_q.push_back('{s1: exp_read(rs1, wr, wa, wd), s2: exp_read(rs2, wr, wa, wd)});
        if (wr && wa != 5'd0) exp_rf[wa] = wd;
      end
      @(posedge clk);
      #1;
    end
    bus.core_rd_req = 1'b0;
    bus.core_wr_req = 1'b0;
  endtask

  task automatic dbg_issue(input logic wr, input logic [4:0] addr, input logic [31:0] wd,
                           output bit granted, output logic wr_en_seen);
    granted    = 1'b0;
    wr_en_seen = 1'b0;
    bus.dbg_req   = 1'b1;
    bus.dbg_wr    = wr;
    bus.dbg_addr  = addr;
    bus.dbg_wdata = wd;
    for (int c = 0; c < 32 && !granted; c++) begin
      @(negedge clk);
      if (bus.dbg_gnt) begin
        granted    = 1'b1;
        wr_en_seen = bus.rf_wr_enabl;
        if (!wr) dbg_q.push_back(exp_read(addr, 1'b0, 5'd0, 32'h0));
        else if (addr != 5'd0) exp_rf[addr] = wd;
      end
      @(posedge clk);
      #1;
    end
    bus.dbg_req = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.core_rd_req = 1'b0; bus.core_wr_req = 1'b0; bus.dbg_req = 1'b0; bus.dbg_wr = 1'b0;
    bus.core_rs1_addr = '0; bus.core_rs2_addr = '0; bus.core_wr_addr = '0;
    bus.core_wr_data = '0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({bus.core_gnt, bus.dbg_gnt, bus.core_rvld, bus.dbg_rvld, bus.init_done,
         bus.rf_reg_enabl, bus.rf_wr_enabl} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl_outputs: got %b required 0", {bus.core_gnt, bus.dbg_gnt,
               bus.core_rvld, bus.dbg_rvld, bus.init_done, bus.rf_reg_enabl, bus.rf_wr_enabl});
    end
    n_checks++;
    if ({bus.rf_src1_addr, bus.rf_src2_addr, bus.rf_dst_addr, bus.rf_dst_data,
         bus.core_src1_data, bus.core_src2_data, bus.dbg_rdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_data_outputs: got nonzero, required 0");
    end
    // Requests held during INIT must not be granted.
    bus.core_rd_req = 1'b1;
    bus.dbg_req     = 1'b1;
    reset = 1'b0;
    #1;
    for (int i = 0; i < 32; i++) begin
      n_checks++;
      if (bus.rf_reg_enabl !== 1'b1 || bus.rf_wr_enabl !== 1'b1 ||
          bus.rf_dst_addr !== 5'(i) || bus.rf_dst_data !== InitVal) begin
        n_fail++;
        $display("FAIL init_write[%0d]: got en=%b we=%b addr=%0d data=%h required 1 1 %0d %h",
                 i, bus.rf_reg_enabl, bus.rf_wr_enabl, bus.rf_dst_addr, bus.rf_dst_data, i,
                 InitVal);
      end
      n_checks++;
      if (bus.core_gnt !== 1'b0 || bus.dbg_gnt !== 1'b0 || bus.init_done !== 1'b0) begin
        n_fail++;
        $display("FAIL init_no_grant[%0d]: got cg=%b dg=%b done=%b required 0 0 0", i,
                 bus.core_gnt, bus.dbg_gnt, bus.init_done);
      end
      @(negedge clk);
      #1;
    end
    bus.core_rd_req = 1'b0;
    bus.dbg_req     = 1'b0;
    n_checks++;
    if (bus.init_done !== 1'b1) begin
      n_fail++;
      $display("FAIL init_done: got %b required 1", bus.init_done);
    end
    for (int i = 0; i < 32; i++) exp_rf[i] = InitVal;
    @(posedge clk);
    #1;
  endtask

  task automatic test_core_rw();
    bit g;
    logic we;
    core_issue(1'b0, 5'd0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF, g, we);
    n_checks++;
    if (!g || we !== 1'b1) begin
      n_fail++;
      $display("FAIL core_write_x5: got gnt=%b we=%b required 1 1", g, we);
    end
    core_issue(1'b1, 5'd5, 5'd0, 1'b0, 5'd0, 32'h0, g, we);
    n_checks++;
    if (!g) begin
      n_fail++;
      $display("FAIL core_read_x5_gnt: got 0 required 1");
    end
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (core_q.size() != 0) begin
      n_fail++;
      $display("FAIL core_read_x5_rvld: got %0d outstanding required 0", core_q.size());
    end
  endtask

  task automatic test_x0();
    bit g;
    logic we;
    core_issue(1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 32'h12345678, g, we);
    n_checks++;
    if (!g || we !== 1'b0) begin
      n_fail++;
      $display("FAIL x0_write_blocked: got gnt=%b we=%b required 1 0", g, we);
    end
    core_issue(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, g, we);
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (!g || core_q.size() != 0) begin
      n_fail++;
      $display("FAIL x0_read: got gnt=%b outstanding=%0d required 1 0", g, core_q.size());
    end
  endtask

  task automatic test_starvation();
    bus.core_rd_req   = 1'b1;
    bus.core_rs1_addr = 5'd5;
    bus.core_rs2_addr = 5'd0;
    bus.dbg_req       = 1'b1;
    bus.dbg_wr        = 1'b0;
    bus.dbg_addr      = 5'd5;
    for (int c = 1; c <= int'(MaxWait) + 1; c++) begin
      @(negedge clk);
      if (bus.core_gnt) core_q.push_back('{s1: exp_rf[5], s2: 32'h0});
      n_checks++;
      if (c <= int'(MaxWait)) begin
        if (bus.dbg_gnt !== 1'b0 || bus.core_gnt !== 1'b1) begin
          n_fail++;
          $display("FAIL starve_deny[%0d]: got dg=%b cg=%b required 0 1", c, bus.dbg_gnt,
                   bus.core_gnt);
        end
      end else begin
        if (bus.dbg_gnt !== 1'b1 || bus.core_gnt !== 1'b0) begin
          n_fail++;
          $display("FAIL starve_force[%0d]: got dg=%b cg=%b required 1 0", c, bus.dbg_gnt,
                   bus.core_gnt);
        end
        if (bus.dbg_gnt) dbg_q.push_back(32'hDEADBEEF);
      end
      @(posedge clk);
      #1;
    end
    bus.dbg_req     = 1'b0;
    bus.core_rd_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (dbg_q.size() != 0 || core_q.size() != 0) begin
      n_fail++;
      $display("FAIL starve_drain: got %0d/%0d outstanding required 0/0", dbg_q.size(),
               core_q.size());
    end
  endtask

  task automatic test_bypass();
    bit g;
    logic we;
    core_issue(1'b1, 5'd7, 5'd0, 1'b1, 5'd7, 32'hA5A5A5A5, g, we);
    core_issue(1'b1, 5'd7, 5'd7, 1'b0, 5'd0, 32'h0, g, we);
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (!g || core_q.size() != 0) begin
      n_fail++;
      $display("FAIL bypass_drain: got gnt=%b outstanding=%0d required 1 0", g, core_q.size());
    end
  endtask

  task automatic test_back_to_back();
    bit g;
    logic we;
    int start;
    int ok = 0;
    start = cyc;
    core_issue(1'b0, 5'd0, 5'd0, 1'b1, 5'd1, 32'h11, g, we);              ok += int'(g);
    core_issue(1'b1, 5'd1, 5'd0, 1'b1, 5'd2, 32'h22, g, we);              ok += int'(g);
    core_issue(1'b1, 5'd1, 5'd2, 1'b0, 5'd0, 32'h0, g, we);               ok += int'(g);
    dbg_issue(1'b1, 5'd9, 32'h99, g, we);                                 ok += int'(g);
    core_issue(1'b1, 5'd9, 5'd2, 1'b1, 5'd2, 32'h2222, g, we);            ok += int'(g);
    dbg_issue(1'b0, 5'd2, 32'h0, g, we);                                  ok += int'(g);
    dbg_issue(1'b1, 5'd0, 32'hFFFF, g, we);                               ok += int'(g);
    n_checks++;
    if (we !== 1'b0) begin
      n_fail++;
      $display("FAIL dbg_x0_write_blocked: got we=%b required 0", we);
    end
    dbg_issue(1'b0, 5'd0, 32'h0, g, we);                                  ok += int'(g);
    n_checks++;
    if (ok != 8 || cyc - start != 8) begin
      n_fail++;
      $display("FAIL b2b_throughput: got %0d grants in %0d cycles required 8 in 8", ok,
               cyc - start);
    end
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (dbg_q.size() != 0 || core_q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_drain: got %0d/%0d outstanding required 0/0", dbg_q.size(),
               core_q.size());
    end
  endtask

  task automatic test_reset_mid();
    bit g;
    logic we;
    bus.dbg_req  = 1'b1;
    bus.dbg_wr   = 1'b0;
    bus.dbg_addr = 5'd5;
    @(negedge clk);
    n_checks++;
    if (bus.dbg_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_gnt: got %b required 1", bus.dbg_gnt);
    end
    #1;
    reset = 1'b1;
    bus.dbg_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.dbg_rvld !== 1'b0 || bus.init_done !== 1'b0) begin
        n_fail++;
        $display("FAIL midrst_rvld[%0d]: got rvld=%b done=%b required 0 0", i, bus.dbg_rvld,
                 bus.init_done);
      end
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (bus.rf_wr_enabl !== 1'b1 || bus.rf_dst_addr !== 5'd0) begin
      n_fail++;
      $display("FAIL midrst_restart: got we=%b addr=%0d required 1 0", bus.rf_wr_enabl,
               bus.rf_dst_addr);
    end
    repeat (32) @(negedge clk);
    #1;
    n_checks++;
    if (bus.init_done !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_init_done: got %b required 1", bus.init_done);
    end
    for (int i = 0; i < 32; i++) exp_rf[i] = InitVal;
    @(posedge clk);
    #1;
    core_issue(1'b1, 5'd5, 5'd7, 1'b0, 5'd0, 32'h0, g, we);
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (!g || core_q.size() != 0 || dbg_q.size() != 0) begin
      n_fail++;
      $display("FAIL midrst_reread: got gnt=%b outstanding=%0d/%0d required 1 0/0", g,
               core_q.size(), dbg_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_core_rw();
    test_x0();
    test_starvation();
    test_bypass();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file_ctrl.md
Name: reg_file_ctrl

Overview:
- Sequences the 32x32 dual-read / single-write BRAM register file.
- Clears all 32 entries after reset. BRAM contents are not reset by hardware.
- Arbitrates register-file access between the core pipeline and the debug port.
- Forces x0 to read as zero and corrects same-cycle write/read collisions. The BRAM is READ_FIRST with a 1-cycle synchronous read.

Parameters:
- DBG_MAX_WAIT, 8: cycles debug may be denied before it is granted ahead of the core. Legal range 1..15.
- INIT_VALUE, 32'h0: value written to every register during the clear sequence.

Ports:
- clk  in  1  cpu clock
- reset  in  1  asynchronous, active-high reset
- core_rd_req  in  1  core read request (rs1 and rs2)
- core_rs1_addr  in  5  core rs1 address
- core_rs2_addr  in  5  core rs2 address
- core_wr_req  in  1  core write request
- core_wr_addr  in  5  core rd address
- core_wr_data  in  32  core write data
- core_gnt  out  1  core access accepted this cycle
- core_rvld  out  1  core read data valid
- core_src1_data  out  32  rs1 data
- core_src2_data  out  32  rs2 data
- dbg_req  in  1  debug access request
- dbg_wr  in  1  1 = write, 0 = read
- dbg_addr  in  5  debug register address
- dbg_wdata  in  32  debug write data
- dbg_gnt  out  1  debug access accepted this cycle
- dbg_rvld  out  1  debug read data valid
- dbg_rdata  out  32  debug read data
- init_done  out  1  clear sequence complete
- rf_reg_enabl  out  1  register file enable
- rf_wr_enabl  out  1  register file write enable
- rf_src1_addr  out  5  register file src1 address
- rf_src2_addr  out  5  register file src2 address
- rf_dst_addr  out  5  register file dst address
- rf_dst_data  out  32  register file write data
- rf_src1_data  in  32  register file src1 read data
- rf_src2_data  in  32  register file src2 read data

Behaviour:
- Reset values: all outputs 0; state INIT; clear counter 0; starvation counter 0.
- Reset asserted mid-operation: state returns to INIT immediately. In-flight reads are dropped; rvld is not asserted for them.
- States: INIT, RUN.
- INIT, per cycle:
  - rf_reg_enabl=1, rf_wr_enabl=1.
  - rf_dst_addr = counter, rf_dst_data = INIT_VALUE; counter increments.
  - After address 31 is written, the next cycle enters RUN and sets init_done=1. This is exactly 32 write cycles after reset deassertion.
  - No grants are issued in INIT.
- RUN:
  - rf_reg_enabl=1 constantly.
  - Each cycle exactly one owner, core or debug, or none.
- Arbitration:
  - core_req = core_rd_req | core_wr_req.
  - Debug is granted if dbg_req and (not core_req, or starvation counter == DBG_MAX_WAIT). Otherwise the core is granted if core_req.
  - core_gnt and dbg_gnt are combinational in the same cycle and never both 1.
  - Starvation counter increments when dbg_req is denied, and clears on dbg_gnt or when dbg_req=0.
  - Requesters hold their request and operands until granted.
- Core grant:
  - rf_src1_addr/rf_src2_addr = rs1/rs2.
  - If core_wr_req: rf_dst_addr/rf_dst_data = core_wr_addr/core_wr_data and rf_wr_enabl=1.
  - A single grant covers read and write together.
- Debug grant:
  - Read: rf_src1_addr = dbg_addr.
  - Write: rf_dst_addr/rf_dst_data = dbg_addr/dbg_wdata, rf_wr_enabl=1.
- Write address 0: rf_wr_enabl is forced to 0 in RUN. INIT still writes address 0.
- Read latency: 1 cycle.
  - core_rvld is pulsed the cycle after a core grant with core_rd_req=1.
  - dbg_rvld is pulsed the cycle after a debug read grant.
  - core_src1_data, core_src2_data and dbg_rdata are valid only while the corresponding rvld is high.
  - A registered read address of 0 forces that output to 0.
- Back-to-back grants every cycle are allowed; throughput is one access per cycle.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined:
  - The write address/data and an "address equal" flag for each read port are registered.
  - If a granted read address equals the same-cycle write address, nonzero, with a write enabled, the returned data is the written data.
- Undefined: the collision returns the old register contents, per READ_FIRST. No bypass registers are built.

Test Plan:
- Assert reset, release -> rf_wr_enabl high for 32 cycles, rf_dst_addr 0..31, INIT_VALUE data; init_done=1 on cycle 33; no grants before then.
- Core writes x5=32'hDEADBEEF, then reads rs1=x5, rs2=x0 -> next cycle core_rvld=1, src1=32'hDEADBEEF, src2=0.
- Core writes x0=32'h12345678, then reads x0 -> data 0; rf_wr_enabl stayed 0.
- Core_req continuous with dbg_req read of x5 -> dbg denied 8 cycles, granted on cycle 9, core_gnt=0 that cycle; dbg_rvld next cycle with 32'hDEADBEEF.
- Same-cycle core write x7=32'hA5A5A5A5 and read rs1=x7 (x7 previously 1) -> RF_BYPASS_EN: 32'hA5A5A5A5; without: 32'h1.
- Reset asserted during a debug read grant -> dbg_rvld stays 0; INIT restarts at address 0.
